// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with registered sync, valid, colour and
// line/frame start outputs.
//   pclk, reset (async, active low)     clock and reset
//   vga_data {R,G,B}, CW bits each      colour for the current h_addr/v_addr
//   h_addr, v_addr                      requested coordinate, 0 outside the active area
//   vga_clk                             copy of pclk
//   hsync, vsync, valid, vga_r/g/b      registered, one pclk after h_addr/v_addr
//   line_start, frame_start             registered one-cycle pulses
// Optional: define TEST_PATTERN_EN to add input pattern_en and an internal 8-bar generator.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CW       = 4,
   parameter int unsigned AW       = 10
) (
   input  logic            pclk,
   input  logic            reset,
`ifdef TEST_PATTERN_EN
   input  logic            pattern_en,
`endif
   input  logic [3*CW-1:0] vga_data,
   output logic [AW-1:0]   h_addr,
   output logic [AW-1:0]   v_addr,
   output logic            vga_clk,
   output logic            hsync,
   output logic            vsync,
   output logic            valid,
   output logic [7:0]      vga_r,
   output logic [7:0]      vga_g,
   output logic [7:0]      vga_b,
   output logic            line_start,
   output logic            frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW     = $clog2(H_TOTAL);
   localparam int unsigned VCW     = $clog2(V_TOTAL);

   localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
   localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
   localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
   localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);

   // MSB-first bit replication of a CW-bit channel up to 8 bits.
   function automatic logic [7:0] expand(input logic [CW-1:0] c);
      logic [7:0] o;
      o = '0;
      for (int k = 0; k < 8; k++) begin
         o[7-k] = c[int'(CW) - 1 - (k % int'(CW))];
      end
      return o;
   endfunction

   logic [HCW-1:0] h_cnt_q, h_cnt_d;
   logic [VCW-1:0] v_cnt_q, v_cnt_d;
   // Counters hold at 0 for one edge after reset so pixel (0,0) is requested for a full cycle.
   logic           run_q, run_d;
   logic           hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;
   logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
   logic           line_q, line_d, frame_q, frame_d;
   logic           active;
   logic [7:0]     src_r, src_g, src_b;

   assign active  = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
   assign h_addr  = active ? AW'(h_cnt_q) : '0;
   assign v_addr  = active ? AW'(v_cnt_q) : '0;
   assign vga_clk = pclk;

   always_comb begin
      run_d   = 1'b1;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (run_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

`ifdef TEST_PATTERN_EN
   localparam int unsigned    BAR_W    = H_ACTIVE / 8;
   localparam logic [HCW-1:0] BAR_LAST = HCW'(BAR_W - 1);

   // Bar index tracks h_cnt; it advances every BAR_W active pixels and saturates at 7.
   logic [HCW-1:0] bar_px_q, bar_px_d;
   logic [2:0]     bar_idx_q, bar_idx_d;

   always_comb begin
      bar_px_d  = bar_px_q;
      bar_idx_d = bar_idx_q;
      if (run_q) begin
         if (h_cnt_q == H_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
         end else if (h_cnt_q < H_ACT_END) begin
            if (bar_px_q == BAR_LAST) begin
               bar_px_d = '0;
               if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
               bar_px_d = bar_px_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         bar_px_q  <= '0;
         bar_idx_q <= '0;
      end else begin
         bar_px_q  <= bar_px_d;
         bar_idx_q <= bar_idx_d;
      end
   end
`endif

   always_comb begin
      src_r = expand(vga_data[3*CW-1:2*CW]);
      src_g = expand(vga_data[2*CW-1:CW]);
      src_b = expand(vga_data[CW-1:0]);
`ifdef TEST_PATTERN_EN
      if (pattern_en) begin
         src_r = {8{bar_idx_q[2]}};
         src_g = {8{bar_idx_q[1]}};
         src_b = {8{bar_idx_q[0]}};
      end
`endif
   end

   always_comb begin
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      valid_d = valid_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      line_d  = line_q;
      frame_d = frame_q;
      if (run_q) begin
         hsync_d = (h_cnt_q >= H_SYNC_BEG && h_cnt_q <= H_SYNC_END) ? HS_POL : ~HS_POL;
         vsync_d = (v_cnt_q >= V_SYNC_BEG && v_cnt_q <= V_SYNC_END) ? VS_POL : ~VS_POL;
         valid_d = active;
         r_d     = active ? src_r : 8'h00;
         g_d     = active ? src_g : 8'h00;
         b_d     = active ? src_b : 8'h00;
         line_d  = active && (h_cnt_q == '0);
         frame_d = active && (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         run_q   <= 1'b0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         valid_q <= 1'b0;
         r_q     <= 8'h00;
         g_q     <= 8'h00;
         b_q     <= 8'h00;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         run_q   <= run_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         valid_q <= valid_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign valid       = valid_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-timing instance and a small-raster instance
// (HS_POL=1, CW=8) checked every cycle against an arithmetic position model, plus
// fixed vectors, per-frame counts and an asynchronous mid-frame reset.
module tb_vga_timing_gen;

   logic pclk = 1'b0;
   logic reset;
   always #5 pclk = ~pclk;

   // Default instance
   logic [11:0] d0;
   logic [9:0]  h_addr0, v_addr0;
   logic        vga_clk0, hsync0, vsync0, valid0, ls0, fs0;
   logic [7:0]  r0, g0, b0;

   vga_timing_gen dut0 (
      .pclk(pclk), .reset(reset), .vga_data(d0), .h_addr(h_addr0), .v_addr(v_addr0),
      .vga_clk(vga_clk0), .hsync(hsync0), .vsync(vsync0), .valid(valid0),
      .vga_r(r0), .vga_g(g0), .vga_b(b0), .line_start(ls0), .frame_start(fs0)
   );

   // Small instance: 24 x 11 total, 16 x 6 active
   logic [23:0] d1;
   logic [4:0]  h_addr1, v_addr1;
   logic        vga_clk1, hsync1, vsync1, valid1, ls1, fs1;
   logic [7:0]  r1, g1, b1;

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b0), .CW(8), .AW(5)
   ) dut1 (
      .pclk(pclk), .reset(reset), .vga_data(d1), .h_addr(h_addr1), .v_addr(v_addr1),
      .vga_clk(vga_clk1), .hsync(hsync1), .vsync(vsync1), .valid(valid1),
      .vga_r(r1), .vga_g(g1), .vga_b(b1), .line_start(ls1), .frame_start(fs1)
   );

   typedef struct packed {
      logic [9:0] ha;
      logic [9:0] va;
      logic       hs;
      logic       vs;
      logic       vl;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       ls;
      logic       fs;
   } px_t;

   typedef struct {
      int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
      bit hpol, vpol;
      int cw;
   } tim_t;

   typedef struct {
      int          p;
      logic [11:0] data;
      logic        hs, vl, ls, fs;
      logic [7:0]  r, g, b;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl [NV];
   tim_t t0, t1;

   int total = 0;
   int bad   = 0;
   int k     = 0;
   bit agg_en = 1'b0;
   int n0_vl = 0, n0_hs = 0, n0_vs = 0, n0_ls = 0, n0_fs = 0;
   int n1_vl = 0, n1_hs = 0, n1_vs = 0, n1_ls = 0, n1_fs = 0;

   function automatic logic [7:0] widen(input int cw, input logic [7:0] c);
      logic [7:0] o;
      o = '0;
      for (int s = 8 - cw; s > -cw; s -= cw) o |= (s >= 0) ? (c << s) : (c >> (-s));
      return o;
   endfunction

   // k = rising edges since reset release: counters sit at position k-1 (0 at k=0),
   // registered outputs show position k-2 (reset values before that).
   function automatic px_t model(input tim_t t, input int kk, input logic [23:0] data);
      int   htot = t.ha + t.hfp + t.hsy + t.hbp;
      int   vtot = t.va + t.vfp + t.vsy + t.vbp;
      int   pa, pr, h, v, mask;
      bit   act;
      px_t  e;
      pa   = (kk >= 1) ? kk - 1 : 0;
      h    = pa % htot;
      v    = (pa / htot) % vtot;
      act  = (h < t.ha) && (v < t.va);
      e.ha = act ? 10'(h) : 10'd0;
      e.va = act ? 10'(v) : 10'd0;
      pr   = kk - 2;
      if (pr < 0) begin
         e.hs = ~t.hpol; e.vs = ~t.vpol; e.vl = 1'b0;
         e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; e.ls = 1'b0; e.fs = 1'b0;
      end else begin
         h    = pr % htot;
         v    = (pr / htot) % vtot;
         act  = (h < t.ha) && (v < t.va);
         mask = (1 << t.cw) - 1;
         e.hs = (h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hsy) ? t.hpol : ~t.hpol;
         e.vs = (v >= t.va + t.vfp && v < t.va + t.vfp + t.vsy) ? t.vpol : ~t.vpol;
         e.vl = act;
         e.r  = act ? widen(t.cw, 8'((data >> (2 * t.cw)) & mask)) : 8'h00;
         e.g  = act ? widen(t.cw, 8'((data >> t.cw) & mask)) : 8'h00;
         e.b  = act ? widen(t.cw, 8'(data & mask)) : 8'h00;
         e.ls = act && (h == 0);
         e.fs = (h == 0) && (v == 0);
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (k=%0d)", nm, a, e, k);
      end
   endtask

   task automatic check_px(input string tag, input px_t a, input px_t e);
      chk({tag, ".h_addr"}, 32'(a.ha), 32'(e.ha));
      chk({tag, ".v_addr"}, 32'(a.va), 32'(e.va));
      chk({tag, ".hsync"}, 32'(a.hs), 32'(e.hs));
      chk({tag, ".vsync"}, 32'(a.vs), 32'(e.vs));
      chk({tag, ".valid"}, 32'(a.vl), 32'(e.vl));
      chk({tag, ".vga_r"}, 32'(a.r), 32'(e.r));
      chk({tag, ".vga_g"}, 32'(a.g), 32'(e.g));
      chk({tag, ".vga_b"}, 32'(a.b), 32'(e.b));
      chk({tag, ".line_start"}, 32'(a.ls), 32'(e.ls));
      chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
   endtask

   function automatic px_t act0();
      return {h_addr0, v_addr0, hsync0, vsync0, valid0, r0, g0, b0, ls0, fs0};
   endfunction

   function automatic px_t act1();
      return {5'd0, h_addr1, 5'd0, v_addr1, hsync1, vsync1, valid1, r1, g1, b1, ls1, fs1};
   endfunction

   // One cycle: drive random (or table) data, clock, check both instances at the negedge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         d0 = 12'($urandom);
         d1 = 24'($urandom);
         for (int j = 0; j < NV; j++) if (k >= 1 && tbl[j].p == k - 1) d0 = tbl[j].data;
         @(posedge pclk);
         k++;
         @(negedge pclk);
         chk("vga_clk0", 32'(vga_clk0), 32'(pclk));
         chk("vga_clk1", 32'(vga_clk1), 32'(pclk));
         check_px("dut0", act0(), model(t0, k, {12'h000, d0}));
         check_px("dut1", act1(), model(t1, k, d1));
         for (int j = 0; j < NV; j++) begin
            if (tbl[j].p == k - 2) begin
               chk($sformatf("vec%0d.hsync", j), 32'(hsync0), 32'(tbl[j].hs));
               chk($sformatf("vec%0d.valid", j), 32'(valid0), 32'(tbl[j].vl));
               chk($sformatf("vec%0d.rgb", j), 32'({r0, g0, b0}),
                   32'({tbl[j].r, tbl[j].g, tbl[j].b}));
               chk($sformatf("vec%0d.line_start", j), 32'(ls0), 32'(tbl[j].ls));
               chk($sformatf("vec%0d.frame_start", j), 32'(fs0), 32'(tbl[j].fs));
            end
         end
         if (agg_en && k >= 2 && k - 2 < 1600) begin
            n0_vl += int'(valid0); n0_hs += int'(!hsync0); n0_vs += int'(!vsync0);
            n0_ls += int'(ls0);    n0_fs += int'(fs0);
         end
         if (agg_en && k >= 2 && k - 2 < 528) begin
            n1_vl += int'(valid1); n1_hs += int'(hsync1); n1_vs += int'(!vsync1);
            n1_ls += int'(ls1);    n1_fs += int'(fs1);
         end
      end
   endtask

   initial begin
      t0 = '{ha: 640, hfp: 16, hsy: 96, hbp: 48, va: 480, vfp: 10, vsy: 2, vbp: 33,
             hpol: 1'b0, vpol: 1'b0, cw: 4};
      t1 = '{ha: 16, hfp: 2, hsy: 3, hbp: 3, va: 6, vfp: 1, vsy: 2, vbp: 2,
             hpol: 1'b1, vpol: 1'b0, cw: 8};
      //          p     data     hs    vl    ls    fs    r      g      b
      tbl[0] = '{0,    12'h9C3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 8'hCC, 8'h33};
      tbl[1] = '{639,  12'h0F0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00};
      tbl[2] = '{640,  12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{655,  12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[4] = '{656,  12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[5] = '{751,  12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[6] = '{752,  12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[7] = '{800,  12'h800, 1'b1, 1'b1, 1'b1, 1'b0, 8'h88, 8'h00, 8'h00};
      tbl[8] = '{2400, 12'h123, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33};
      tbl[9] = '{2405, 12'hA5F, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hFF};

      reset = 1'b0;
      d0    = '0;
      d1    = '0;
      repeat (3) @(negedge pclk);
      check_px("rst0", act0(), model(t0, 0, 24'h0));
      check_px("rst1", act1(), model(t1, 0, 24'h0));
      chk("rst hsync0", 32'(hsync0), 32'd1);
      chk("rst hsync1", 32'(hsync1), 32'd0);

      reset  = 1'b1;
      k      = 0;
      agg_en = 1'b1;
      run(2600);
      agg_en = 1'b0;

      chk("dut0 valid count", 32'(n0_vl), 32'd1280);
      chk("dut0 hsync low count", 32'(n0_hs), 32'd192);
      chk("dut0 vsync low count", 32'(n0_vs), 32'd0);
      chk("dut0 line_start count", 32'(n0_ls), 32'd2);
      chk("dut0 frame_start count", 32'(n0_fs), 32'd1);
      chk("dut1 valid count", 32'(n1_vl), 32'd192);
      chk("dut1 hsync active count", 32'(n1_hs), 32'd66);
      chk("dut1 vsync low count", 32'(n1_vs), 32'd96);
      chk("dut1 line_start count", 32'(n1_ls), 32'd12);
      chk("dut1 frame_start count", 32'(n1_fs), 32'd2);

      // Advance dut1 to h=10, v=3, then reset off-edge.
      for (int i = 0; i < 264 && ((k - 1) % 264) != 82; i++) run(1);
      @(posedge pclk);
      #1;
      chk("pre-reset valid1", 32'(valid1), 32'd1);
      #1 reset = 1'b0;
      #1;
      check_px("async rst0", act0(), model(t0, 0, 24'h0));
      check_px("async rst1", act1(), model(t1, 0, 24'h0));
      chk("async rst valid1", 32'(valid1), 32'd0);
      chk("async rst hsync1", 32'(hsync1), 32'd0);
      repeat (2) @(negedge pclk);
      chk("held rst valid0", 32'(valid0), 32'd0);
      chk("held rst r1", 32'(r1), 32'd0);
      @(posedge pclk);
      #3 reset = 1'b1;
      @(negedge pclk);
      k = 0;
      run(1);
      chk("edge1 frame_start0", 32'(fs0), 32'd0);
      chk("edge1 frame_start1", 32'(fs1), 32'd0);
      chk("edge1 h_addr1", 32'(h_addr1), 32'd0);
      run(1);
      chk("edge2 frame_start0", 32'(fs0), 32'd1);
      chk("edge2 frame_start1", 32'(fs1), 32'd1);
      run(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
